// File: rtl/peribus_pkg.sv
// Shared peribus definitions: bus widths, window size, timer register offsets and CTRL bit layout.
// Latency: n/a (constants, types and a pure window-decode helper).
// Backpressure: n/a; peribus responders never stall the bus.
package peribus_pkg;

    localparam int PERI_DATA_W    = 16;
    localparam int PERI_ADDR_W    = 8;
    localparam int PERI_WIN_WORDS = 8;

    // Word offsets inside the timer window.
    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_PRESC  = 3'd1;
    localparam logic [2:0] TMR_RELOAD = 3'd2;
    localparam logic [2:0] TMR_COUNT  = 3'd3;
    localparam logic [2:0] TMR_STATUS = 3'd4;

    // CTRL bit indices.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic en;
    } tmr_ctrl_t;

    // True when a falls in the PERI_WIN_WORDS-word window starting at base (modular, so windows may wrap).
    function automatic logic peri_in_window(input logic [PERI_ADDR_W-1:0] a,
                                            input logic [PERI_ADDR_W-1:0] base);
        logic [PERI_ADDR_W-1:0] off;
        off = a - base;
        return off < PERI_ADDR_W'(PERI_WIN_WORDS);
    endfunction

endpackage

// File: rtl/peribus_strobe_sync.sv
// Two-flop synchronizer for an asynchronous bus strobe plus rising-edge detector giving a 1-cycle pulse.
// Latency: o_pulse is high in the cycle after the 2nd clk edge that samples the strobe high.
// Backpressure: none; a strobe held high yields exactly one pulse.
// Ports: clk, reset_bar (async active-low), i_strobe (async level), o_pulse (1-cycle, clk domain).
module peribus_strobe_sync (
    input  logic clk,
    input  logic reset_bar,
    input  logic i_strobe,
    output logic o_pulse
);

    // All flops hold the inverted strobe, so their reset value of 0 means "strobe seen high".
    // A strobe already high when reset releases therefore cannot fake an edge; it must go low first.
    logic r_meta_n;
    logic r_sync_n;
    logic r_prev_n;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_meta_n <= 1'b0;
            r_sync_n <= 1'b0;
            r_prev_n <= 1'b0;
        end else begin
            r_meta_n <= ~i_strobe;
            r_sync_n <= r_meta_n;
            r_prev_n <= r_sync_n;
        end
    end

    // Synchronized strobe high now, low one cycle ago.
    assign o_pulse = ~r_sync_n & r_prev_n;

endmodule

// File: rtl/peribus_timer.sv
// Peribus timer responder: 16-bit down counter with prescaler, auto-reload/one-shot and maskable overflow irq.
// Latency: writes land on the 4th clk edge after write_enable rises; read_data is registered, 1 clk after addr/read_enable.
// Backpressure: none; one write per strobe, reads drive 0 when not selected so responders can be OR-combined.
// Ports: clk, reset_bar (async active-low), addr, write_data, write_enable/read_enable (async strobes),
//        read_data (registered, 0 when unselected), irq (registered STATUS.OVF & CTRL.IRQ_EN).
module peribus_timer
    import peribus_pkg::*;
#(
    parameter logic [PERI_ADDR_W-1:0] BASE_ADDR = 8'h10
) (
    input  logic                   clk,
    input  logic                   reset_bar,
    input  logic [PERI_ADDR_W-1:0] addr,
    input  logic [PERI_DATA_W-1:0] write_data,
    input  logic                   write_enable,
    input  logic                   read_enable,
    output logic [PERI_DATA_W-1:0] read_data,
    output logic                   irq
);

    logic                   w_wr_pulse;
    logic                   r_wr_vld;
    logic [PERI_ADDR_W-1:0] r_hold_addr;
    logic [PERI_DATA_W-1:0] r_hold_data;

    tmr_ctrl_t              r_ctrl;
    logic [PERI_DATA_W-1:0] r_presc;
    logic [PERI_DATA_W-1:0] r_reload;
    logic [PERI_DATA_W-1:0] r_count;
    logic                   r_ovf;
    logic [PERI_DATA_W-1:0] r_pcnt;
    logic                   r_irq;
    logic [PERI_DATA_W-1:0] r_read_data;

    peribus_strobe_sync u_wr_sync (
        .clk      (clk),
        .reset_bar(reset_bar),
        .i_strobe (write_enable),
        .o_pulse  (w_wr_pulse)
    );

    // Low offset bits depend only on low address bits, so the 3-bit index needs no full subtraction.
    logic [2:0] w_wr_idx;
    logic       w_wr_hit;
    logic       w_wr_ctrl;
    logic       w_wr_presc;
    logic       w_wr_reload;
    logic       w_wr_count;
    logic       w_wr_status;

    assign w_wr_idx    = r_hold_addr[2:0] - BASE_ADDR[2:0];
    assign w_wr_hit    = r_wr_vld && peri_in_window(r_hold_addr, BASE_ADDR);
    assign w_wr_ctrl   = w_wr_hit && (w_wr_idx == TMR_CTRL);
    assign w_wr_presc  = w_wr_hit && (w_wr_idx == TMR_PRESC);
    assign w_wr_reload = w_wr_hit && (w_wr_idx == TMR_RELOAD);
    assign w_wr_count  = w_wr_hit && (w_wr_idx == TMR_COUNT);
    assign w_wr_status = w_wr_hit && (w_wr_idx == TMR_STATUS);

    logic                   w_tick;
    logic                   w_ovf_set;
    logic                   w_ovf_nxt;
    tmr_ctrl_t              w_ctrl_nxt;
    logic [PERI_DATA_W-1:0] w_count_nxt;
    logic [PERI_DATA_W-1:0] w_pcnt_nxt;

    always_comb begin
        w_tick      = r_ctrl.en && (r_pcnt == r_presc);
        w_ovf_set   = 1'b0;
        w_ctrl_nxt  = r_ctrl;
        w_count_nxt = r_count;

        if (w_wr_ctrl) begin
            w_ctrl_nxt.en      = r_hold_data[CTRL_EN];
            w_ctrl_nxt.oneshot = r_hold_data[CTRL_ONESHOT];
            w_ctrl_nxt.irq_en  = r_hold_data[CTRL_IRQ_EN];
        end

        // Bus writes to COUNT or CTRL win over a coincident tick; that tick is simply lost.
        if (w_wr_count) begin
            w_count_nxt = r_hold_data;
        end else if (w_tick && !w_wr_ctrl) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - 16'd1;
            end else begin
                w_ovf_set   = 1'b1;
                w_count_nxt = r_reload;
                if (r_ctrl.oneshot) begin
                    w_ctrl_nxt.en = 1'b0;
                end
            end
        end

        // A COUNT write restarts the prescaler so the new count gets full tick periods.
        if (w_wr_count || !r_ctrl.en || w_tick) begin
            w_pcnt_nxt = '0;
        end else begin
            w_pcnt_nxt = r_pcnt + 16'd1;
        end

        // A new overflow beats a same-cycle write-1-to-clear.
        w_ovf_nxt = w_ovf_set | (r_ovf & ~(w_wr_status & r_hold_data[0]));
    end

    logic [2:0]             w_rd_idx;
    logic [PERI_DATA_W-1:0] w_rd_val;

    assign w_rd_idx = addr[2:0] - BASE_ADDR[2:0];

    always_comb begin
        w_rd_val = '0;
        if (read_enable && peri_in_window(addr, BASE_ADDR)) begin
            case (w_rd_idx)
                TMR_CTRL:   w_rd_val = {{(PERI_DATA_W-3){1'b0}}, r_ctrl};
                TMR_PRESC:  w_rd_val = r_presc;
                TMR_RELOAD: w_rd_val = r_reload;
                TMR_COUNT:  w_rd_val = r_count;
                TMR_STATUS: w_rd_val = {{(PERI_DATA_W-1){1'b0}}, r_ovf};
                default:    w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_wr_vld    <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_ctrl      <= '0;
            r_presc     <= '0;
            r_reload    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_pcnt      <= '0;
            r_irq       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_wr_vld <= w_wr_pulse;
            if (w_wr_pulse) begin
                r_hold_addr <= addr;
                r_hold_data <= write_data;
            end
            if (w_wr_presc) begin
                r_presc <= r_hold_data;
            end
            if (w_wr_reload) begin
                r_reload <= r_hold_data;
            end
            r_ctrl      <= w_ctrl_nxt;
            r_count     <= w_count_nxt;
            r_ovf       <= w_ovf_nxt;
            r_pcnt      <= w_pcnt_nxt;
            // Built from next-state values so irq moves on the same edge as OVF/IRQ_EN.
            r_irq       <= w_ovf_nxt & w_ctrl_nxt.irq_en;
            r_read_data <= w_rd_val;
        end
    end

    assign read_data = r_read_data;
    assign irq       = r_irq;

endmodule

// File: tb/tb_peribus_timer.sv
// Self-checking bench for peribus_timer: directed bus sequences with hand-computed expectations
// plus a per-cycle behavioural model of the register map, timer rules and strobe handling.
// Inputs change on falling clk edges; outputs are sampled 1 time unit after rising edges.
module tb_peribus_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic        clk = 1'b0;
    logic        reset_bar;
    logic [7:0]  addr;
    logic [15:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] read_data;
    logic        irq;

    always #5 clk = ~clk;

    peribus_timer #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset_bar   (reset_bar),
        .addr        (addr),
        .write_data  (write_data),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .read_data   (read_data),
        .irq         (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en, m_one, m_ie, m_ovf, m_irq;
    logic [15:0] m_presc, m_reload, m_count, m_pc, m_rd;
    // Strobe/addr/data as seen at the last four rising edges; [0] is the most recent.
    logic        h_we   [4];
    logic [7:0]  h_addr [4];
    logic [15:0] h_dat  [4];

    function automatic logic [15:0] m_reg(input logic [7:0] a);
        logic [7:0] off;
        off = a - BASE;
        case (off)
            8'd0:    return {13'd0, m_ie, m_one, m_en};
            8'd1:    return m_presc;
            8'd2:    return m_reload;
            8'd3:    return m_count;
            8'd4:    return {15'd0, m_ovf};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_one = 0; m_ie = 0; m_ovf = 0; m_irq = 0;
        m_presc = 0; m_reload = 0; m_count = 0; m_pc = 0; m_rd = 0;
        // Before reset release the strobe counts as high: a write needs a fresh low-to-high.
        for (int i = 0; i < 4; i++) begin
            h_we[i] = 1'b1; h_addr[i] = 8'h00; h_dat[i] = 16'h0000;
        end
    endtask

    task automatic model_step();
        logic        wr, tick, set_ovf, n_en, n_one, n_ie, n_ovf;
        logic [7:0]  woff;
        logic [15:0] wd, n_presc, n_reload, n_count, n_pc;
        // Write takes effect on the 4th edge after the strobe is first sampled high.
        wr   = h_we[2] && !h_we[3];
        woff = h_addr[2] - BASE;
        wd   = h_dat[2];
        m_rd = read_enable ? m_reg(addr) : 16'h0000;
        tick = m_en && (m_pc == m_presc);
        n_en = m_en; n_one = m_one; n_ie = m_ie; n_ovf = m_ovf;
        n_presc = m_presc; n_reload = m_reload; n_count = m_count;
        set_ovf = 1'b0;
        if (wr && woff == 8'd0) {n_ie, n_one, n_en} = wd[2:0];
        if (wr && woff == 8'd1) n_presc = wd;
        if (wr && woff == 8'd2) n_reload = wd;
        if (wr && woff == 8'd3) n_count = wd;
        else if (tick && !(wr && woff == 8'd0)) begin
            if (m_count != 16'd0) n_count = m_count - 16'd1;
            else begin
                set_ovf = 1'b1;
                n_count = m_reload;
                if (m_one) n_en = 1'b0;
            end
        end
        if (set_ovf) n_ovf = 1'b1;
        else if (wr && woff == 8'd4 && wd[0]) n_ovf = 1'b0;
        if (!m_en || tick || (wr && woff == 8'd3)) n_pc = 16'd0;
        else n_pc = m_pc + 16'd1;
        for (int i = 3; i > 0; i--) begin
            h_we[i] = h_we[i-1]; h_addr[i] = h_addr[i-1]; h_dat[i] = h_dat[i-1];
        end
        h_we[0] = write_enable; h_addr[0] = addr; h_dat[0] = write_data;
        m_en = n_en; m_one = n_one; m_ie = n_ie; m_ovf = n_ovf;
        m_presc = n_presc; m_reload = n_reload; m_count = n_count; m_pc = n_pc;
        m_irq = n_ovf & n_ie;
    endtask

    always begin
        @(posedge clk or negedge reset_bar);
        if (!reset_bar) model_reset();
        else model_step();
        #1;
        chk("cyc_read_data", read_data, m_rd);
        chk("cyc_irq", {15'd0, irq}, {15'd0, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    // Strobe high for 4 clocks; returns on the falling edge just after the register updated.
    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; write_data = d; write_enable = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] v);
        @(negedge clk);
        addr = a; read_enable = 1'b1;
        @(posedge clk);
        #1 v = read_data;
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    logic [15:0] v;

    initial begin
        reset_bar = 1'b0; addr = 8'h00; write_data = 16'h0000;
        write_enable = 1'b0; read_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_read_data", read_data, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        reset_bar = 1'b1;

        // Register write/read and decode.
        bus_write(8'h12, 16'h0003);
        bus_read(8'h12, v);  chk("read_reload", v, 16'h0003);
        bus_read(8'h40, v);  chk("read_outside", v, 16'h0000);
        bus_write(8'h15, 16'hBEEF);
        bus_read(8'h15, v);  chk("read_reserved", v, 16'h0000);

        // Auto-reload: PRESC=0, COUNT=2, CTRL=EN|IRQ_EN; OVF 3 clk after EN, then every 4.
        bus_write(8'h11, 16'h0000);
        bus_write(8'h13, 16'h0002);
        bus_write(8'h10, 16'h0005);
        at_edge();
        at_edge();  chk("irq_before_ovf", {15'd0, irq}, 16'h0000);
        at_edge();  chk("irq_first_ovf", {15'd0, irq}, 16'h0001);
        // This W1C lands exactly on the next overflow: OVF must stay set.
        bus_write(8'h14, 16'h0001);
        at_edge();  chk("w1c_collide_keep", {15'd0, irq}, 16'h0001);
        // This W1C lands one clk after an overflow: irq drops, then returns 3 clk later.
        bus_write(8'h14, 16'h0001);
        at_edge();  chk("irq_cleared", {15'd0, irq}, 16'h0000);
        at_edge();  chk("irq_still_clear", {15'd0, irq}, 16'h0000);
        at_edge();  chk("irq_ovf_again", {15'd0, irq}, 16'h0001);
        // COUNT write coincides with an overflow tick: loads 9, decrements once before the read.
        bus_write(8'h13, 16'h0009);
        bus_read(8'h13, v);  chk("count_write_vs_tick", v, 16'h0008);

        // Long strobe (20 clk) loading COUNT=5 while counting: exactly one load.
        @(negedge clk);
        addr = 8'h13; write_data = 16'h0005; write_enable = 1'b1;
        repeat (20) @(negedge clk);
        write_enable = 1'b0;
        bus_read(8'h13, v);  chk("long_strobe_count_a", v, 16'h0000);
        bus_read(8'h13, v);  chk("long_strobe_count_b", v, 16'h0002);

        // One-shot with prescaler: PRESC=1, COUNT=1, CTRL=EN|ONESHOT -> OVF 4 clk after EN.
        bus_write(8'h10, 16'h0000);
        bus_write(8'h14, 16'h0001);
        bus_write(8'h11, 16'h0001);
        bus_write(8'h13, 16'h0001);
        bus_write(8'h10, 16'h0003);
        addr = 8'h14; read_enable = 1'b1;
        repeat (4) at_edge();
        chk("oneshot_ovf_pre", read_data, 16'h0000);
        at_edge();
        chk("oneshot_ovf_set", read_data, 16'h0001);
        chk("oneshot_irq_masked", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        read_enable = 1'b0;
        bus_read(8'h10, v);  chk("oneshot_ctrl", v, 16'h0002);
        bus_read(8'h13, v);  chk("oneshot_count_reload", v, 16'h0003);
        repeat (10) @(negedge clk);
        bus_read(8'h13, v);  chk("oneshot_count_hold", v, 16'h0003);

        // Async reset mid-count with irq high, then a strobe held high across release.
        bus_write(8'h12, 16'h0100);
        bus_write(8'h11, 16'h0000);
        bus_write(8'h13, 16'h0001);
        bus_write(8'h10, 16'h0005);
        addr = 8'h13; read_enable = 1'b1;
        repeat (5) at_edge();
        chk("pre_reset_irq", {15'd0, irq}, 16'h0001);
        chk("pre_reset_count", read_data, 16'h00FE);
        #2;
        reset_bar = 1'b0;
        write_data = 16'h0055; write_enable = 1'b1;
        #1;
        chk("async_reset_read_data", read_data, 16'h0000);
        chk("async_reset_irq", {15'd0, irq}, 16'h0000);
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_strobe_no_write", read_data, 16'h0000);
        write_enable = 1'b0;
        repeat (2) @(negedge clk);
        write_enable = 1'b1;
        repeat (4) @(negedge clk);
        write_enable = 1'b0;
        @(negedge clk);
        chk("write_after_toggle", read_data, 16'h0055);
        read_enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
